// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. It holds the PC, selects the next PC and drives the
//   byte address into a combinational instruction memory that returns the word
//   in the same cycle. The returned word is registered into IF/ID together with
//   its PC and PC+4 for the decode stage.
//
//   Control priority on each clock edge:
//     redirect > stall > halt detect > normal advance
//   Fetch halts on an all-zero instruction word (unused memory). It leaves the
//   halted state only on a redirect or a reset.
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   NOP_INSTR   word driven on id_instr when IF/ID holds no valid instruction
//
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   imem_pc         byte address to instruction memory (= current PC)
//   imem_instr      instruction word for imem_pc, returned in the same cycle
//   stall           hold PC and IF/ID contents
//   redirect_valid  branch/jump taken; load redirect_pc
//   redirect_pc     redirect target byte address
//   id_valid        IF/ID holds a real instruction
//   id_pc           PC of id_instr
//   id_pc_plus4     id_pc + 4
//   id_instr        registered instruction
//   halted          fetch stopped on a zero word
//   misalign_err    sticky: a redirect target had bits[1:0] != 0
//
// Optional feature (macro FETCH_STATS_EN):
//   fetch_count     edges that loaded a valid instruction into IF/ID (wraps)
//   flush_count     redirects that discarded a valid IF/ID entry (wraps)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic        halted,
`ifdef FETCH_STATS_EN
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count,
`endif
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_next_seq;

  // 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0, for both the PC and id_pc_plus4.
  assign pc_next_seq = pc_q + 32'd4;

  assign imem_pc = pc_q;

  // halted is a pure decode of the state register, so it carries no
  // combinational path from any input.
  assign halted = (state_q == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      id_valid     <= 1'b0;
      id_pc        <= 32'h0;
      id_pc_plus4  <= 32'h0;
      id_instr     <= NOP_INSTR;
      misalign_err <= 1'b0;
`ifdef FETCH_STATS_EN
      fetch_count  <= 32'h0;
      flush_count  <= 16'h0;
`endif
    end else if (redirect_valid) begin
      // NOTE: every register here uses non-blocking assignment so all state
      // updates see the pre-edge values (e.g. flush_count reads the old id_valid).
      pc_q     <= {redirect_pc[31:2], 2'b00};
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      state_q  <= RUN;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err <= 1'b1;
      end
`ifdef FETCH_STATS_EN
      if (id_valid) begin
        flush_count <= flush_count + 16'd1;
      end
`endif
    end else begin
      case (state_q)
        BOOT: begin
          // One settling cycle after reset; PC held, IF/ID stays empty.
          state_q <= RUN;
        end
        RUN: begin
          if (stall) begin
            // Hold everything; no halt detection while stalled.
          end else if (imem_instr == 32'h0) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            state_q  <= HALT;
          end else begin
            id_instr    <= imem_instr;
            id_pc       <= pc_q;
            id_pc_plus4 <= pc_next_seq;
            id_valid    <= 1'b1;
            pc_q        <= pc_next_seq;
`ifdef FETCH_STATS_EN
            fetch_count <= fetch_count + 32'd1;
`endif
          end
        end
        HALT: begin
          // Parked until redirect or reset; stall has no effect here.
          id_valid <= 1'b0;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

endmodule
